// File: rtl/vram_arbiter_pkg.sv
// Shared tag and CPU-state encodings for the VRAM arbiter.
// Imported by the arbiter top and its read-tag pipe.
package vram_arbiter_pkg;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_CPU  = 2'd1,
      TAG_VGA  = 2'd2
   } tag_e;

   typedef enum logic [1:0] {
      C_IDLE = 2'd0,
      C_PEND = 2'd1,
      C_ACK  = 2'd2
   } cstate_e;

endpackage

// File: rtl/vram_arbiter_rd_tag_pipe.sv
// Shift register carrying the owner tag of each issued RAM read.
// Its output lines up with the cycle that read data appears on ram_dout.
module rd_tag_pipe
   import vram_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  tag_e i_tag,
   output tag_e o_tag_out,
   output tag_e o_tag_pre
);

   tag_e r_tags [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_tags[i] <= TAG_NONE;
         end
      end else begin
         r_tags[0] <= i_tag;
         for (int i = 1; i < DEPTH; i++) begin
            r_tags[i] <= r_tags[i-1];
         end
      end
   end

   assign o_tag_out = r_tags[DEPTH-1];
   // One stage early, so the CPU FSM can be in C_ACK when data lands
   assign o_tag_pre = r_tags[DEPTH-2];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between the CPU bus port and the VGA fetcher.
// VGA has priority, bounded by a streak limit so a waiting CPU always progresses.
module vram_arbiter
   import vram_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int READ_LAT   = 1,
   parameter int MAX_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam int SW = $clog2(MAX_STREAK + 1);
   localparam logic [SW-1:0] MAX_S = SW'(MAX_STREAK);

   cstate_e           r_state;
   cstate_e           w_state_nx;
   logic [SW-1:0]     r_streak;
   logic [ADDR_W-1:0] r_ram_addr;
   logic              r_ram_we;
   logic [DATA_W-1:0] r_ram_din;
   logic [DATA_W-1:0] r_cpu_rdata;

   logic w_cpu_ok;
   logic w_vga_gnt;
   logic w_cpu_gnt;
   logic w_cpu_hit;
   tag_e w_tag_in;
   tag_e w_tag_out;
   tag_e w_tag_pre;

   assign w_cpu_ok  = cpu_req & (r_state == C_IDLE);
   assign w_vga_gnt = ~rst & vga_req & (~w_cpu_ok | (r_streak < MAX_S));
   assign w_cpu_gnt = ~rst & w_cpu_ok & ~w_vga_gnt;

   always_comb begin
      w_tag_in = TAG_NONE;
      if (w_vga_gnt) begin
         w_tag_in = TAG_VGA;
      end else if (w_cpu_gnt & ~cpu_we) begin
         w_tag_in = TAG_CPU;
      end
   end

   rd_tag_pipe #(
      .DEPTH(READ_LAT + 1)
   ) u_tags (
      .clk      (clk),
      .rst      (rst),
      .i_tag    (w_tag_in),
      .o_tag_out(w_tag_out),
      .o_tag_pre(w_tag_pre)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_streak <= '0;
      end else if (~w_cpu_ok | w_cpu_gnt) begin
         r_streak <= '0;
      end else if (w_vga_gnt && (r_streak < MAX_S)) begin
         r_streak <= r_streak + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ram_addr <= '0;
         r_ram_we   <= 1'b0;
         r_ram_din  <= '0;
      end else begin
         r_ram_we <= w_cpu_gnt & cpu_we;
         if (w_vga_gnt) begin
            r_ram_addr <= vga_addr;
         end else if (w_cpu_gnt) begin
            r_ram_addr <= cpu_addr;
            if (cpu_we) begin
               r_ram_din <= cpu_wdata;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= C_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         C_IDLE: begin
            if (w_cpu_gnt) begin
               w_state_nx = cpu_we ? C_ACK : C_PEND;
            end
         end
         C_PEND: begin
            if (w_tag_pre == TAG_CPU) begin
               w_state_nx = C_ACK;
            end
         end
         C_ACK:   w_state_nx = C_IDLE;
         default: w_state_nx = C_IDLE;
      endcase
   end

   assign w_cpu_hit = (w_tag_out == TAG_CPU);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cpu_rdata <= '0;
      end else if (w_cpu_hit) begin
         r_cpu_rdata <= ram_dout;
      end
   end

   // Bypass in the ack cycle; the register holds it until the next read ack
   assign cpu_rdata  = w_cpu_hit ? ram_dout : r_cpu_rdata;
   assign cpu_ack    = (r_state == C_ACK);
   assign vga_gnt    = w_vga_gnt;
   assign vga_rvalid = (w_tag_out == TAG_VGA);
   assign vga_rdata  = ram_dout;
   assign ram_addr   = r_ram_addr;
   assign ram_we     = r_ram_we;
   assign ram_din    = r_ram_din;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural RAM model.
module tb_vram_arbiter;

   parameter int RL = 1;

   typedef struct {
      int          cyc;
      logic        rd;
      logic [31:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [9:0]  cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_ack;
   logic [31:0] cpu_rdata;
   logic        vga_req = 1'b1;
   logic [9:0]  vga_addr = '0;
   logic        vga_gnt;
   logic        vga_rvalid;
   logic [31:0] vga_rdata;
   logic [9:0]  ram_addr;
   logic        ram_we;
   logic [31:0] ram_din;
   logic [31:0] ram_dout;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   exp_t cq[$];
   exp_t vq[$];
   int gnt_log[$];
   exp_t me;
   exp_t mv;

   vram_arbiter #(
      .ADDR_W(10), .DATA_W(32), .READ_LAT(RL), .MAX_STREAK(4)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
      .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
      .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM: unwritten words read 0xC0DE0000|addr, except 0x020 = 0x11111111
   logic [31:0] mem [1024];
   logic        wr  [1024];
   logic [31:0] rd_pipe [RL];
   logic [31:0] w_rd_now;
   always_comb begin
      if (wr[ram_addr]) w_rd_now = mem[ram_addr];
      else if (ram_addr == 10'h020) w_rd_now = 32'h1111_1111;
      else w_rd_now = 32'hC0DE_0000 | {22'd0, ram_addr};
   end
   always @(posedge clk) begin
      if (cyc == 0) begin
         for (int i = 0; i < 1024; i++) wr[i] <= 1'b0;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_din;
         wr[ram_addr]  <= 1'b1;
      end
      rd_pipe[0] <= w_rd_now;
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign ram_dout = rd_pipe[RL-1];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (cpu_ack) begin
         if (cq.size() == 0) begin
            chk("cpu_ack_unexpected", 32'd1, 32'd0);
         end else begin
            me = cq.pop_front();
            chk("cpu_ack_cycle", cyc, me.cyc);
            if (me.rd) chk("cpu_rdata", cpu_rdata, me.d);
         end
      end
      if (vga_rvalid) begin
         if (vq.size() == 0) begin
            chk("vga_rvalid_unexpected", 32'd1, 32'd0);
         end else begin
            mv = vq.pop_front();
            chk("vga_rvalid_cycle", cyc, mv.cyc);
            chk("vga_rdata", vga_rdata, mv.d);
         end
      end
   end

   task automatic cpu_op(input logic we, input logic [9:0] a,
                         input logic [31:0] d, input int lat);
      int g = 0;
      bit got = 0;
      cq.push_back('{cyc + lat, ~we, d});
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      while (!got && g < 100) begin
         @(negedge clk);
         if (cpu_ack) begin
            got = 1;
            if (we) begin
               chk("wr_ram_we", {31'd0, ram_we}, 32'd1);
               chk("wr_ram_addr", {22'd0, ram_addr}, {22'd0, a});
               chk("wr_ram_din", ram_din, d);
            end
         end
         tick();
         g++;
      end
      cpu_req = 1'b0;
      if (!got) chk("cpu_ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic vga_burst(input logic [9:0] base, input int n,
                            input logic [31:0] d0);
      int k = 0;
      int g = 0;
      vga_req = 1'b1;
      vga_addr = base;
      while (k < n && g < 200) begin
         @(negedge clk);
         if (vga_gnt) begin
            vq.push_back('{cyc + 1 + RL, 1'b1, d0 + 32'(k)});
            gnt_log.push_back(cyc);
            k++;
         end
         tick();
         vga_addr = base + 10'(k);
         g++;
      end
      vga_req = 1'b0;
      if (k < n) chk("vga_gnt_timeout", 32'(k), 32'(n));
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_ack"}, {31'd0, cpu_ack}, 32'd0);
      chk({nm, "_rvalid"}, {31'd0, vga_rvalid}, 32'd0);
      chk({nm, "_gnt"}, {31'd0, vga_gnt}, 32'd0);
      chk({nm, "_ram_we"}, {31'd0, ram_we}, 32'd0);
      chk({nm, "_ram_addr"}, {22'd0, ram_addr}, 32'd0);
      chk({nm, "_ram_din"}, ram_din, 32'd0);
      chk({nm, "_rdata"}, cpu_rdata, 32'd0);
   endtask

   int exp3 [8] = '{0, 1, 2, 3, 5, 6, 7, 8};
   int t0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // reset with a VGA request pending: no grant allowed
      @(negedge clk);
      chk_reset_outs("reset");
      tick();
      rst = 1'b0;
      vga_req = 1'b0;
      repeat (2) tick();

      // 1: write then read back
      cpu_op(1'b1, 10'h010, 32'hDEAD_BEEF, 1);
      cpu_op(1'b0, 10'h010, 32'hDEAD_BEEF, 1 + RL);
      repeat (3) tick();

      // 2: 8-word VGA burst, back-to-back grants
      gnt_log.delete();
      vga_burst(10'h100, 8, 32'hC0DE_0100);
      chk("burst_gnts", 32'(gnt_log.size()), 32'd8);
      for (int i = 1; i < 8 && i < gnt_log.size(); i++)
         chk("burst_gnt_cycle", 32'(gnt_log[i]), 32'(gnt_log[0] + i));
      repeat (RL + 3) tick();

      // 3: starvation guard, CPU wins after 4 VGA grants
      gnt_log.delete();
      t0 = cyc;
      fork
         vga_burst(10'h200, 8, 32'hC0DE_0200);
         cpu_op(1'b0, 10'h010, 32'hDEAD_BEEF, 5 + RL);
      join
      for (int i = 0; i < 8 && i < gnt_log.size(); i++)
         chk("streak_gnt_cycle", 32'(gnt_log[i]), 32'(t0 + exp3[i]));
      repeat (RL + 3) tick();

      // 4: collision, VGA reads old data, then new data
      fork
         vga_burst(10'h020, 1, 32'h1111_1111);
         cpu_op(1'b1, 10'h020, 32'h2222_2222, 2);
      join
      vga_burst(10'h020, 1, 32'h2222_2222);
      repeat (RL + 3) tick();

      // 5: reset in the cycle after a CPU read grant
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
      tick();
      rst = 1'b1; cpu_req = 1'b0; vga_req = 1'b1;
      @(negedge clk);
      chk_reset_outs("midrst");
      tick();
      rst = 1'b0; vga_req = 1'b0;
      repeat (RL + 4) tick();
      cpu_op(1'b1, 10'h030, 32'h5A5A_5A5A, 1);
      cpu_op(1'b0, 10'h030, 32'h5A5A_5A5A, 1 + RL);

      repeat (RL + 4) tick();
      chk("cpu_queue_drained", 32'(cq.size()), 32'd0);
      chk("vga_queue_drained", 32'(vq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
